// File: rtl/full_adder.sv
// Ripple-carry full adder: {C, S} = x + y + Cin built from 1-bit cells,
// plus a one-cycle registered copy (S_q, C_q) cleared by synchronous rst.
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             C,
  output logic [WIDTH-1:0] S_q,
  output logic             C_q
);

  // A zero-width adder has no meaning; stop elaboration rather than build one.
  if (WIDTH < 1) begin : g_bad_width
    $error("full_adder: WIDTH must be >= 1 (got %0d)", WIDTH);
  end

  // carry[i] is the carry into bit i; carry[WIDTH] is the carry-out.
  logic [WIDTH:0] carry;

  assign carry[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign S[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i+1] = (x[i] & y[i]) | (x[i] & carry[i]) | (y[i] & carry[i]);
  end

  assign C = carry[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      S_q <= '0;
      C_q <= 1'b0;
    end else begin
      S_q <= S;
      C_q <= C;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder at WIDTH 1, 4 and 8: exhaustive 1-bit table, carry
// chains, registered path/reset behaviour, and 1000 random 8-bit vectors.
module tb_full_adder;

  logic clk;
  logic rst;

  logic       x1, y1, cin1;
  logic       s1, c1, s1_q, c1_q;

  logic [3:0] x4, y4;
  logic       cin4;
  logic [3:0] s4, s4_q;
  logic       c4, c4_q;

  logic [7:0] x8, y8;
  logic       cin8;
  logic [7:0] s8, s8_q;
  logic       c8, c8_q;

  int checks;
  int errors;

  logic [8:0] exp_q[$];

  // {C,S} for (x,y,Cin) = 000..111, entry v at bits [2v+1:2v]
  localparam logic [15:0] W1_TBL = {2'b11, 2'b10, 2'b10, 2'b01,
                                    2'b10, 2'b01, 2'b01, 2'b00};

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .x(x1), .y(y1), .Cin(cin1),
    .S(s1), .C(c1), .S_q(s1_q), .C_q(c1_q)
  );

  full_adder #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .x(x4), .y(y4), .Cin(cin4),
    .S(s4), .C(c4), .S_q(s4_q), .C_q(c4_q)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .x(x8), .y(y8), .Cin(cin8),
    .S(s8), .C(c8), .S_q(s8_q), .C_q(c8_q)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: plain arithmetic at 9 bits
  function automatic logic [8:0] ref_add8(input logic [7:0] a, input logic [7:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {8'd0, c};
  endfunction

  function automatic logic [4:0] ref_add4(input logic [3:0] a, input logic [3:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {4'd0, c};
  endfunction

  // driver tasks
  task automatic drive_w1(input logic a, input logic b, input logic c);
    x1 = a; y1 = b; cin1 = c;
  endtask

  task automatic drive_w4(input logic [3:0] a, input logic [3:0] b, input logic c);
    x4 = a; y4 = b; cin4 = c;
  endtask

  task automatic drive_w8(input logic [7:0] a, input logic [7:0] b, input logic c);
    x8 = a; y8 = b; cin8 = c;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_w1(1'b1, 1'b1, 1'b1);
    drive_w4(4'hF, 4'hF, 1'b1);
    drive_w8(8'hFF, 8'hFF, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({c1_q, s1_q} !== 2'b00) begin
      errors++;
      $display("FAIL reset_w1: got %b expected 00", {c1_q, s1_q});
    end
    checks++;
    if ({c4_q, s4_q} !== 5'h00) begin
      errors++;
      $display("FAIL reset_w4: got %h expected 00", {c4_q, s4_q});
    end
    checks++;
    if ({c8_q, s8_q} !== 9'h000) begin
      errors++;
      $display("FAIL reset_w8: got %h expected 000", {c8_q, s8_q});
    end
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] exp;
    rst = 1'b0;
    for (int v = 0; v < 8; v++) begin
      @(posedge clk); #1;
      drive_w1(v[2], v[1], v[0]);
      exp = W1_TBL[2*v +: 2];
      #2;
      checks++;
      if ({c1, s1} !== exp) begin
        errors++;
        $display("FAIL exhaustive_w1 v=%0d: got %b expected %b", v, {c1, s1}, exp);
      end
    end
  endtask

  task automatic test_comb_timing();
    @(negedge clk); #1;
    rst = 1'b1;
    drive_w1(1'b0, 1'b1, 1'b1);
    drive_w4(4'h7, 4'h8, 1'b1);
    #1;
    checks++;
    if ({c1, s1} !== 2'b10) begin
      errors++;
      $display("FAIL comb_timing_w1: got %b expected 10", {c1, s1});
    end
    checks++;
    if ({c4, s4} !== 5'h10) begin
      errors++;
      $display("FAIL comb_timing_w4: got %h expected 10", {c4, s4});
    end
    rst = 1'b0;
    drive_w4(4'h3, 4'h4, 1'b0);
    #1;
    checks++;
    if ({c4, s4} !== 5'h07) begin
      errors++;
      $display("FAIL comb_timing_w4_rst_low: got %h expected 07", {c4, s4});
    end
  endtask

  task automatic test_registered();
    @(posedge clk); #1;
    rst = 1'b0;
    drive_w1(1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++;
    if ({c1_q, s1_q} !== 2'b10) begin
      errors++;
      $display("FAIL registered_110: got C_q,S_q=%b expected 10", {c1_q, s1_q});
    end
    drive_w1(1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    checks++;
    if ({c1_q, s1_q} !== 2'b01) begin
      errors++;
      $display("FAIL registered_001: got C_q,S_q=%b expected 01", {c1_q, s1_q});
    end
  endtask

  task automatic test_reset_mid();
    drive_w1(1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      checks++;
      if ({c1_q, s1_q} !== 2'b00) begin
        errors++;
        $display("FAIL reset_mid_reg edge=%0d: got %b expected 00", e, {c1_q, s1_q});
      end
      checks++;
      if ({c1, s1} !== 2'b11) begin
        errors++;
        $display("FAIL reset_mid_comb edge=%0d: got %b expected 11", e, {c1, s1});
      end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({c1_q, s1_q} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: got %b expected 11", {c1_q, s1_q});
    end
  endtask

  task automatic test_carry_w4();
    logic [3:0] xs [3] = '{4'hF, 4'hF, 4'h5};
    logic [3:0] ys [3] = '{4'h1, 4'hF, 4'hA};
    logic       cs [3] = '{1'b0, 1'b1, 1'b0};
    logic [4:0] want [3] = '{5'h10, 5'h1F, 5'h0F};
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      drive_w4(xs[k], ys[k], cs[k]);
      #1;
      checks++;
      if ({c4, s4} !== want[k]) begin
        errors++;
        $display("FAIL carry_w4 k=%0d: got %h expected %h", k, {c4, s4}, want[k]);
      end
      checks++;
      if ({c4, s4} !== ref_add4(xs[k], ys[k], cs[k])) begin
        errors++;
        $display("FAIL carry_w4_model k=%0d: got %h expected %h", k, {c4, s4},
                 ref_add4(xs[k], ys[k], cs[k]));
      end
      @(posedge clk); #1;
      checks++;
      if ({c4_q, s4_q} !== want[k]) begin
        errors++;
        $display("FAIL carry_w4_reg k=%0d: got %h expected %h", k, {c4_q, s4_q}, want[k]);
      end
    end
  endtask

  task automatic test_random_w8();
    logic [7:0] a, b;
    logic       c;
    logic [8:0] exp;
    logic [8:0] exp_reg;
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() > 0) begin
        exp_reg = exp_q.pop_front();
        checks++;
        if ({c8_q, s8_q} !== exp_reg) begin
          errors++;
          $display("FAIL random_w8_reg i=%0d: got %h expected %h", i, {c8_q, s8_q}, exp_reg);
        end
      end
      if (i == 0) begin
        a = 8'hFF; b = 8'hFF; c = 1'b1;
      end else if (i == 1) begin
        a = 8'h00; b = 8'h00; c = 1'b0;
      end else begin
        a = 8'($urandom_range(255, 0));
        b = 8'($urandom_range(255, 0));
        c = 1'($urandom_range(1, 0));
      end
      drive_w8(a, b, c);
      exp = ref_add8(a, b, c);
      #1;
      checks++;
      if ({c8, s8} !== exp) begin
        errors++;
        $display("FAIL random_w8_comb i=%0d x=%h y=%h cin=%b: got %h expected %h",
                 i, a, b, c, {c8, s8}, exp);
      end
      exp_q.push_back(exp);
    end
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      exp_reg = exp_q.pop_front();
      checks++;
      if ({c8_q, s8_q} !== exp_reg) begin
        errors++;
        $display("FAIL random_w8_reg_last: got %h expected %h", {c8_q, s8_q}, exp_reg);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    drive_w1(1'b0, 1'b0, 1'b0);
    drive_w4(4'h0, 4'h0, 1'b0);
    drive_w8(8'h00, 8'h00, 1'b0);
    test_reset();
    test_exhaustive_w1();
    test_comb_timing();
    test_registered();
    test_reset_mid();
    test_carry_w4();
    test_random_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
